// File: rtl/pifo_pkg.sv
// Shared definitions for the PIFO enqueue agent: FSM encoding, SUME tuser
// field positions and the destination-port decode.
package pifo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WRITE     = 3'd1,
        ST_DROP      = 3'd2,
        ST_WAIT_ADDR = 3'd3,
        ST_ISSUE     = 3'd4
    } pifo_state_e;

    localparam int SUME_DST_POS = 24;
    localparam int SUME_RI_POS  = 32;
    localparam int MAX_PORTS    = 32;

    function automatic int ri_width(input int rank_w, input int flow_w,
                                    input int block_w, input int queue_w);
        return rank_w + flow_w + block_w + queue_w;
    endfunction

    // Even dst bits map to physical ports 0..3; every odd (DMA) bit folds
    // into each port from 4 upward.
    function automatic logic [MAX_PORTS-1:0] port_mask(input logic [7:0] dst,
                                                       input int port_num);
        logic [MAX_PORTS-1:0] m;
        logic                 dma;
        dma  = dst[1] | dst[3] | dst[5] | dst[7];
        m    = {MAX_PORTS{dma}};
        m[0] = dst[0];
        m[1] = dst[2];
        m[2] = dst[4];
        m[3] = dst[6];
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (i >= port_num) begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/pifo_addr_collector.sv
// Collects the buffer manager's packet/metadata address strobes into sticky
// latches and times out if both do not arrive while waiting.
module pifo_addr_collector
    import pifo_pkg::*;
#(
    parameter int PKT_ADDR_WIDTH  = 11,
    parameter int META_ADDR_WIDTH = 11,
    parameter int ADDR_TIMEOUT    = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       capture_en,
    input  logic                       count_en,
    input  logic                       clear,
    input  logic [PKT_ADDR_WIDTH-1:0]  pkt_addr_in,
    input  logic                       pkt_addr_valid,
    input  logic [META_ADDR_WIDTH-1:0] meta_addr_in,
    input  logic                       meta_addr_valid,
    output logic [PKT_ADDR_WIDTH-1:0]  pkt_addr,
    output logic [META_ADDR_WIDTH-1:0] meta_addr,
    output logic                       both_valid,
    output logic                       timeout
);

    localparam int                   TIMER_W    = $clog2(ADDR_TIMEOUT + 1);
    localparam logic [TIMER_W-1:0]   TIMER_LAST = TIMER_W'(ADDR_TIMEOUT - 1);

    logic                       pkt_flag_q, pkt_flag_d;
    logic                       meta_flag_q, meta_flag_d;
    logic [PKT_ADDR_WIDTH-1:0]  pkt_addr_q, pkt_addr_d;
    logic [META_ADDR_WIDTH-1:0] meta_addr_q, meta_addr_d;
    logic [TIMER_W-1:0]         timer_q, timer_d;

    // A repeated strobe simply overwrites the held address (last one wins).
    always_comb begin
        pkt_flag_d  = pkt_flag_q;
        meta_flag_d = meta_flag_q;
        pkt_addr_d  = pkt_addr_q;
        meta_addr_d = meta_addr_q;
        if (clear) begin
            pkt_flag_d  = 1'b0;
            meta_flag_d = 1'b0;
        end else if (capture_en) begin
            if (pkt_addr_valid) begin
                pkt_flag_d = 1'b1;
                pkt_addr_d = pkt_addr_in;
            end
            if (meta_addr_valid) begin
                meta_flag_d = 1'b1;
                meta_addr_d = meta_addr_in;
            end
        end
        timer_d = (count_en && !clear) ? timer_q + 1'b1 : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_flag_q  <= 1'b0;
            meta_flag_q <= 1'b0;
            pkt_addr_q  <= '0;
            meta_addr_q <= '0;
            timer_q     <= '0;
        end else begin
            pkt_flag_q  <= pkt_flag_d;
            meta_flag_q <= meta_flag_d;
            pkt_addr_q  <= pkt_addr_d;
            meta_addr_q <= meta_addr_d;
            timer_q     <= timer_d;
        end
    end

    assign pkt_addr   = pkt_addr_q;
    assign meta_addr  = meta_addr_q;
    assign both_valid = pkt_flag_q && meta_flag_q;
    assign timeout    = count_en && (timer_q == TIMER_LAST);

endmodule

// File: rtl/pifo_enqueue_agent.sv
// PIFO ingress stage: per-packet admit/drop at SOP, beat streaming to the
// buffer manager, then one registered multicast write to the PIFO blocks.
module pifo_enqueue_agent
    import pifo_pkg::*;
#(
    parameter int DATA_WIDTH          = 256,
    parameter int SUME_META_WIDTH     = 128,
    parameter int PORT_NUM            = 5,
    parameter int DST_POS             = SUME_DST_POS,
    parameter int RI_POS              = SUME_RI_POS,
    parameter int RANK_WIDTH          = 16,
    parameter int FLOW_WIDTH          = 10,
    parameter int PIFO_QUEUE_ID_WIDTH = 5,
    parameter int PIFO_BLOCK_ID_WIDTH = 3,
    parameter int PKT_ADDR_WIDTH      = 11,
    parameter int META_ADDR_WIDTH     = 11,
    parameter int ADDR_TIMEOUT        = 64,
    parameter int CNT_WIDTH           = 32,
    localparam int RI_W = ri_width(RANK_WIDTH, FLOW_WIDTH, PIFO_BLOCK_ID_WIDTH, PIFO_QUEUE_ID_WIDTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]      s_axis_tkeep,
    input  logic [SUME_META_WIDTH-1:0]   s_axis_tuser,
    input  logic                         s_axis_tvalid,
    input  logic                         s_axis_tlast,
    output logic                         s_axis_tready,
    input  logic [PKT_ADDR_WIDTH-1:0]    s_axis_packet_addr,
    input  logic                         s_axis_packet_addr_valid,
    input  logic [META_ADDR_WIDTH-1:0]   s_axis_meta_addr,
    input  logic                         s_axis_meta_addr_valid,
    input  logic [PORT_NUM-1:0]          s_axis_data_buffer_is_almost_full_array,
    input  logic [PORT_NUM-1:0]          s_axis_meta_buffer_is_almost_full_array,
    input  logic [PORT_NUM-1:0]          s_axis_pifo_block_is_full_array,
    output logic [DATA_WIDTH-1:0]        m_axis_to_bm_tdata,
    output logic [DATA_WIDTH/8-1:0]      m_axis_to_bm_tkeep,
    output logic                         m_axis_to_bm_tlast,
    output logic                         m_axis_to_bm_data_wr_en,
    output logic [SUME_META_WIDTH-1:0]   m_axis_to_bm_user_data,
    output logic                         m_axis_to_bm_user_wr_en,
    output logic [PORT_NUM-1:0]          m_axis_to_bm_port_mask,
    output logic                         m_axis_to_pb_valid,
    output logic [PKT_ADDR_WIDTH-1:0]    m_axis_to_pb_packet_addr,
    output logic [META_ADDR_WIDTH-1:0]   m_axis_to_pb_meta_addr,
    output logic [PORT_NUM*RI_W-1:0]     m_axis_to_pb_rank_info,
    output logic [PORT_NUM-1:0]          m_axis_to_pb_wr_en_array,
    output logic [CNT_WIDTH-1:0]         stat_pkt_accepted,
    output logic [CNT_WIDTH-1:0]         stat_pkt_dropped,
    output logic [CNT_WIDTH-1:0]         stat_addr_timeout,
    output logic [CNT_WIDTH-1:0]         stat_pifo_skip
);

    pifo_state_e                state_q, state_d;

    logic [PORT_NUM-1:0]        sop_mask;
    logic [PORT_NUM-1:0]        busy;
    logic                       admit;
    logic                       beat_hs;
    logic                       sop_hs;
    logic                       tready;
    logic                       data_wr_en;
    logic                       user_wr_en;
    logic [PORT_NUM-1:0]        bm_port_mask;
    logic                       capture_en;
    logic                       count_en;
    logic                       col_clear;
    logic                       both_valid;
    logic                       addr_timeout;
    logic                       abort;
    logic [PKT_ADDR_WIDTH-1:0]  col_pkt_addr;
    logic [META_ADDR_WIDTH-1:0] col_meta_addr;

    logic [PORT_NUM-1:0]        mask_q, mask_d;
    logic [RI_W-1:0]            ri_q, ri_d;
    logic                       pb_valid_q, pb_valid_d;
    logic [PKT_ADDR_WIDTH-1:0]  pb_pkt_addr_q, pb_pkt_addr_d;
    logic [META_ADDR_WIDTH-1:0] pb_meta_addr_q, pb_meta_addr_d;
    logic [PORT_NUM*RI_W-1:0]   pb_rank_info_q, pb_rank_info_d;
    logic [PORT_NUM-1:0]        pb_wr_en_q, pb_wr_en_d;
    logic [CNT_WIDTH-1:0]       accepted_q, accepted_d;
    logic [CNT_WIDTH-1:0]       dropped_q, dropped_d;
    logic [CNT_WIDTH-1:0]       timeout_cnt_q, timeout_cnt_d;
    logic [CNT_WIDTH-1:0]       skip_q, skip_d;
    logic [PORT_NUM-1:0]        skip_bits;
    logic [CNT_WIDTH-1:0]       skip_n;

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [CNT_WIDTH-1:0] b);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
    endfunction

    // Any targeted port that is busy rejects the whole packet.
    assign busy     = s_axis_data_buffer_is_almost_full_array
                    | s_axis_meta_buffer_is_almost_full_array
                    | s_axis_pifo_block_is_full_array;
    assign sop_mask = PORT_NUM'(port_mask(s_axis_tuser[DST_POS +: 8], PORT_NUM));
    assign admit    = (sop_mask != '0) && ((sop_mask & busy) == '0);
    assign beat_hs  = s_axis_tvalid && tready;
    assign sop_hs   = (state_q == ST_IDLE) && beat_hs;
    assign abort    = addr_timeout && !both_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (sop_hs) begin
                    if (admit) begin
                        state_d = s_axis_tlast ? ST_WAIT_ADDR : ST_WRITE;
                    end else begin
                        state_d = s_axis_tlast ? ST_IDLE : ST_DROP;
                    end
                end
            end
            ST_WRITE: begin
                if (beat_hs && s_axis_tlast) begin
                    state_d = ST_WAIT_ADDR;
                end
            end
            ST_DROP: begin
                if (beat_hs && s_axis_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_ADDR: begin
                if (both_valid) begin
                    state_d = ST_ISSUE;
                end else if (addr_timeout) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs are forced low while reset is held.
    always_comb begin
        tready       = 1'b0;
        data_wr_en   = 1'b0;
        user_wr_en   = 1'b0;
        bm_port_mask = mask_q;
        capture_en   = 1'b0;
        count_en     = 1'b0;
        col_clear    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tready       = 1'b1;
                data_wr_en   = s_axis_tvalid && admit;
                user_wr_en   = s_axis_tvalid && admit;
                bm_port_mask = sop_mask;
            end
            ST_WRITE: begin
                tready     = 1'b1;
                data_wr_en = s_axis_tvalid;
                capture_en = 1'b1;
            end
            ST_DROP: begin
                tready = 1'b1;
            end
            ST_WAIT_ADDR: begin
                capture_en = 1'b1;
                count_en   = 1'b1;
                col_clear  = abort;
            end
            ST_ISSUE: begin
                col_clear = 1'b1;
            end
            default: begin
                tready = 1'b0;
            end
        endcase
        if (!reset) begin
            tready     = 1'b0;
            data_wr_en = 1'b0;
            user_wr_en = 1'b0;
        end
    end

    always_comb begin
        skip_bits = mask_q & s_axis_pifo_block_is_full_array;
        skip_n    = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            skip_n = skip_n + CNT_WIDTH'(skip_bits[i]);
        end
    end

    always_comb begin
        mask_d         = mask_q;
        ri_d           = ri_q;
        pb_valid_d     = 1'b0;
        pb_wr_en_d     = '0;
        pb_pkt_addr_d  = pb_pkt_addr_q;
        pb_meta_addr_d = pb_meta_addr_q;
        pb_rank_info_d = pb_rank_info_q;
        accepted_d     = accepted_q;
        dropped_d      = dropped_q;
        timeout_cnt_d  = timeout_cnt_q;
        skip_d         = skip_q;
        if (sop_hs) begin
            mask_d = sop_mask;
            ri_d   = s_axis_tuser[RI_POS +: RI_W];
            if (!admit) begin
                dropped_d = sat_add(dropped_q, CNT_WIDTH'(1));
            end
        end
        if (state_q == ST_WAIT_ADDR && abort) begin
            timeout_cnt_d = sat_add(timeout_cnt_q, CNT_WIDTH'(1));
        end
        // Block fullness is re-sampled here; full blocks are skipped, not retried.
        if (state_q == ST_ISSUE) begin
            pb_valid_d     = 1'b1;
            pb_wr_en_d     = mask_q & ~s_axis_pifo_block_is_full_array;
            pb_pkt_addr_d  = col_pkt_addr;
            pb_meta_addr_d = col_meta_addr;
            pb_rank_info_d = {PORT_NUM{ri_q}};
            accepted_d     = sat_add(accepted_q, CNT_WIDTH'(1));
            skip_d         = sat_add(skip_q, skip_n);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q         <= '0;
            ri_q           <= '0;
            pb_valid_q     <= 1'b0;
            pb_wr_en_q     <= '0;
            pb_pkt_addr_q  <= '0;
            pb_meta_addr_q <= '0;
            pb_rank_info_q <= '0;
            accepted_q     <= '0;
            dropped_q      <= '0;
            timeout_cnt_q  <= '0;
            skip_q         <= '0;
        end else begin
            mask_q         <= mask_d;
            ri_q           <= ri_d;
            pb_valid_q     <= pb_valid_d;
            pb_wr_en_q     <= pb_wr_en_d;
            pb_pkt_addr_q  <= pb_pkt_addr_d;
            pb_meta_addr_q <= pb_meta_addr_d;
            pb_rank_info_q <= pb_rank_info_d;
            accepted_q     <= accepted_d;
            dropped_q      <= dropped_d;
            timeout_cnt_q  <= timeout_cnt_d;
            skip_q         <= skip_d;
        end
    end

    pifo_addr_collector #(
        .PKT_ADDR_WIDTH  (PKT_ADDR_WIDTH),
        .META_ADDR_WIDTH (META_ADDR_WIDTH),
        .ADDR_TIMEOUT    (ADDR_TIMEOUT)
    ) u_addr_collector (
        .clk             (clk),
        .rst_n           (reset),
        .capture_en      (capture_en),
        .count_en        (count_en),
        .clear           (col_clear),
        .pkt_addr_in     (s_axis_packet_addr),
        .pkt_addr_valid  (s_axis_packet_addr_valid),
        .meta_addr_in    (s_axis_meta_addr),
        .meta_addr_valid (s_axis_meta_addr_valid),
        .pkt_addr        (col_pkt_addr),
        .meta_addr       (col_meta_addr),
        .both_valid      (both_valid),
        .timeout         (addr_timeout)
    );

    assign s_axis_tready            = tready;
    assign m_axis_to_bm_tdata       = s_axis_tdata;
    assign m_axis_to_bm_tkeep       = s_axis_tkeep;
    assign m_axis_to_bm_tlast       = s_axis_tlast;
    assign m_axis_to_bm_data_wr_en  = data_wr_en;
    assign m_axis_to_bm_user_data   = s_axis_tuser;
    assign m_axis_to_bm_user_wr_en  = user_wr_en;
    assign m_axis_to_bm_port_mask   = bm_port_mask;
    assign m_axis_to_pb_valid       = pb_valid_q;
    assign m_axis_to_pb_packet_addr = pb_pkt_addr_q;
    assign m_axis_to_pb_meta_addr   = pb_meta_addr_q;
    assign m_axis_to_pb_rank_info   = pb_rank_info_q;
    assign m_axis_to_pb_wr_en_array = pb_wr_en_q;
    assign stat_pkt_accepted        = accepted_q;
    assign stat_pkt_dropped         = dropped_q;
    assign stat_addr_timeout        = timeout_cnt_q;
    assign stat_pifo_skip           = skip_q;

endmodule

// File: tb/tb_pifo_enqueue_agent.sv
// Randomised packet-level bench for pifo_enqueue_agent, checked against a
// transaction model of admission, address collection and PIFO issue.
module tb_pifo_enqueue_agent;

    localparam int DW      = 256;
    localparam int MW      = 128;
    localparam int PN      = 5;
    localparam int DST_POS = 24;
    localparam int RI_POS  = 32;
    localparam int RI_W    = 34;
    localparam int PAW     = 11;
    localparam int MAW     = 11;
    localparam int TO      = 64;
    localparam int CW      = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [DW-1:0]     tdata = '0;
    logic [DW/8-1:0]   tkeep = '0;
    logic [MW-1:0]     tuser = '0;
    logic              tvalid = 1'b0;
    logic              tlast = 1'b0;
    logic              tready;
    logic [PAW-1:0]    pkt_addr = '0;
    logic              pkt_addr_valid = 1'b0;
    logic [MAW-1:0]    meta_addr = '0;
    logic              meta_addr_valid = 1'b0;
    logic [PN-1:0]     data_af = '0;
    logic [PN-1:0]     meta_af = '0;
    logic [PN-1:0]     pifo_full = '0;
    logic [DW-1:0]     bm_tdata;
    logic [DW/8-1:0]   bm_tkeep;
    logic              bm_tlast;
    logic              data_wr_en;
    logic [MW-1:0]     bm_user;
    logic              user_wr_en;
    logic [PN-1:0]     bm_port_mask;
    logic              pb_valid;
    logic [PAW-1:0]    pb_pkt_addr;
    logic [MAW-1:0]    pb_meta_addr;
    logic [PN*RI_W-1:0] pb_rank_info;
    logic [PN-1:0]     pb_wr_en;
    logic [CW-1:0]     stat_acc, stat_drop, stat_to, stat_skip;

    int test_count = 0;
    int fail_count = 0;
    int exp_acc = 0, exp_drop = 0, exp_to = 0, exp_skip = 0;

    int                 obs_issued;
    int                 wait_cycles;
    logic               last_tready;
    logic [PAW-1:0]     obs_paddr;
    logic [MAW-1:0]     obs_maddr;
    logic [PN-1:0]      obs_wr_en;
    logic [PN*RI_W-1:0] obs_rank;

    always #5 clk = ~clk;

    pifo_enqueue_agent dut (
        .clk                                     (clk),
        .reset                                   (reset),
        .s_axis_tdata                            (tdata),
        .s_axis_tkeep                            (tkeep),
        .s_axis_tuser                            (tuser),
        .s_axis_tvalid                           (tvalid),
        .s_axis_tlast                            (tlast),
        .s_axis_tready                           (tready),
        .s_axis_packet_addr                      (pkt_addr),
        .s_axis_packet_addr_valid                (pkt_addr_valid),
        .s_axis_meta_addr                        (meta_addr),
        .s_axis_meta_addr_valid                  (meta_addr_valid),
        .s_axis_data_buffer_is_almost_full_array (data_af),
        .s_axis_meta_buffer_is_almost_full_array (meta_af),
        .s_axis_pifo_block_is_full_array         (pifo_full),
        .m_axis_to_bm_tdata                      (bm_tdata),
        .m_axis_to_bm_tkeep                      (bm_tkeep),
        .m_axis_to_bm_tlast                      (bm_tlast),
        .m_axis_to_bm_data_wr_en                 (data_wr_en),
        .m_axis_to_bm_user_data                  (bm_user),
        .m_axis_to_bm_user_wr_en                 (user_wr_en),
        .m_axis_to_bm_port_mask                  (bm_port_mask),
        .m_axis_to_pb_valid                      (pb_valid),
        .m_axis_to_pb_packet_addr                (pb_pkt_addr),
        .m_axis_to_pb_meta_addr                  (pb_meta_addr),
        .m_axis_to_pb_rank_info                  (pb_rank_info),
        .m_axis_to_pb_wr_en_array                (pb_wr_en),
        .stat_pkt_accepted                       (stat_acc),
        .stat_pkt_dropped                        (stat_drop),
        .stat_addr_timeout                       (stat_to),
        .stat_pifo_skip                          (stat_skip)
    );

    task automatic check_output(input string tag, input logic [255:0] actual,
                                input logic [255:0] expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Destination decode from the SUME dst byte: even bits are NF ports, odd bits are DMA.
    function automatic logic [PN-1:0] model_mask(input logic [7:0] dst);
        logic [PN-1:0] m;
        for (int p = 0; p < PN; p++) begin
            if (p < 4) m[p] = ((dst >> (2 * p)) & 8'h01) != 8'h00;
            else       m[p] = (dst & 8'hAA) != 8'h00;
        end
        return m;
    endfunction

    function automatic logic [PN-1:0] rand_sparse(input int one_in);
        logic [PN-1:0] v;
        for (int p = 0; p < PN; p++) v[p] = ($urandom_range(0, one_in - 1) == 0);
        return v;
    endfunction

    task automatic tick();
        @(negedge clk);
        if (pb_valid) begin
            obs_issued++;
            obs_paddr = pb_pkt_addr;
            obs_maddr = pb_meta_addr;
            obs_wr_en = pb_wr_en;
            obs_rank  = pb_rank_info;
        end
        if (!tready) wait_cycles++;
        last_tready = tready;
        @(posedge clk);
        #1;
    endtask

    task automatic check_stats(input string phase);
        check_output({phase, "_stat_acc"},  stat_acc,  exp_acc);
        check_output({phase, "_stat_drop"}, stat_drop, exp_drop);
        check_output({phase, "_stat_to"},   stat_to,   exp_to);
        check_output({phase, "_stat_skip"}, stat_skip, exp_skip);
    endtask

    task automatic apply_stimulus(input logic [7:0] dst, input int len,
                                  input logic [PN-1:0] daf, input logic [PN-1:0] maf,
                                  input logic [PN-1:0] full_sop, input logic [PN-1:0] full_wait,
                                  input bit early_pkt, input bit twice, input bit meta_missing,
                                  input logic [PAW-1:0] paddr, input logic [MAW-1:0] maddr);
        logic [PN-1:0]   mask;
        bit              admit;
        bit              pkt_sent;
        bit              done;
        logic [RI_W-1:0] ri;
        logic [DW-1:0]   data;
        mask     = model_mask(dst);
        admit    = (mask != '0) && ((mask & (daf | maf | full_sop)) == '0);
        ri       = RI_W'({$urandom, $urandom});
        pkt_sent = 1'b0;
        data_af  = daf;
        meta_af  = maf;
        pifo_full = full_sop;
        for (int b = 0; b < len; b++) begin
            data   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            tdata  = data;
            tkeep  = '1;
            tvalid = 1'b1;
            tlast  = (b == len - 1);
            tuser  = {$urandom, $urandom, $urandom, $urandom};
            if (b == 0) begin
                tuser[DST_POS +: 8]  = dst;
                tuser[RI_POS +: RI_W] = ri;
            end
            if (admit && early_pkt && b == 1) begin
                pkt_addr_valid = 1'b1;
                pkt_addr       = twice ? ~paddr : paddr;
                pkt_sent       = 1'b1;
            end
            if (!admit && b == 0) begin
                pkt_addr_valid  = 1'b1;
                meta_addr_valid = 1'b1;
                pkt_addr        = PAW'($urandom);
                meta_addr       = MAW'($urandom);
            end
            @(negedge clk);
            check_output("beat_tready", tready, 1'b1);
            check_output("data_wr_en", data_wr_en, admit);
            check_output("user_wr_en", user_wr_en, admit && (b == 0));
            if (admit) check_output("bm_port_mask", bm_port_mask, mask);
            if (b == 0) check_output("bm_tdata", bm_tdata, data);
            @(posedge clk);
            #1;
            pkt_addr_valid  = 1'b0;
            meta_addr_valid = 1'b0;
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        if (!admit) begin
            exp_drop++;
            tick();
            check_output("drop_back_idle", last_tready, 1'b1);
            check_stats("drop");
            return;
        end
        pifo_full   = full_wait;
        obs_issued  = 0;
        wait_cycles = 0;
        if (!pkt_sent || twice) begin
            pkt_addr_valid = 1'b1;
            pkt_addr       = paddr;
            tick();
            pkt_addr_valid = 1'b0;
        end
        repeat ($urandom_range(0, 2)) tick();
        if (!meta_missing) begin
            meta_addr_valid = 1'b1;
            meta_addr       = maddr;
            tick();
            meta_addr_valid = 1'b0;
        end
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            tick();
            done = last_tready;
        end
        check_output("wait_bounded", done, 1'b1);
        if (meta_missing) begin
            exp_to++;
            check_output("timeout_no_issue", obs_issued, 0);
            check_output("timeout_cycles", wait_cycles, TO);
        end else begin
            exp_acc++;
            exp_skip += $countones(mask & full_wait);
            check_output("issue_count", obs_issued, 1);
            check_output("pb_pkt_addr", obs_paddr, paddr);
            check_output("pb_meta_addr", obs_maddr, maddr);
            check_output("pb_wr_en", obs_wr_en, mask & ~full_wait);
            check_output("pb_rank_info", obs_rank, {PN{ri}});
        end
        pifo_full = '0;
        check_stats("pkt");
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] dst;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_pb_valid", pb_valid, 1'b0);
        check_output("rst_pb_wr_en", pb_wr_en, '0);
        check_output("rst_pb_addr", {pb_pkt_addr, pb_meta_addr}, '0);
        check_output("rst_rank", pb_rank_info, '0);
        check_stats("rst");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] directed unicast / drop / multicast / timeout");
        apply_stimulus(8'h04, 3, '0, '0, '0, '0, 1'b1, 1'b0, 1'b0, 11'h012, 11'h007);
        apply_stimulus(8'h01, 4, 5'b00001, '0, '0, '0, 1'b0, 1'b0, 1'b0, 11'h000, 11'h000);
        apply_stimulus(8'h05, 2, '0, '0, '0, 5'b00010, 1'b1, 1'b0, 1'b0, 11'h155, 11'h0AA);
        meta_addr_valid = 1'b1;
        meta_addr       = 11'h3FF;
        tick();
        meta_addr_valid = 1'b0;
        apply_stimulus(8'h40, 1, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 11'h021, 11'h000);
        apply_stimulus(8'h10, 2, '0, '0, '0, '0, 1'b1, 1'b1, 1'b0, 11'h0F0, 11'h00F);

        $display("[TB] randomized packets");
        for (int k = 0; k < 40; k++) begin
            dst = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            apply_stimulus(dst, $urandom_range(1, 4), rand_sparse(10), rand_sparse(10),
                           rand_sparse(10), rand_sparse(4), 1'($urandom), 1'($urandom),
                           ($urandom_range(0, 11) == 0), PAW'($urandom), MAW'($urandom));
        end

        $display("[TB] reset during WRITE");
        tuser = '0;
        tuser[DST_POS +: 8] = 8'h10;
        tvalid = 1'b1;
        tlast  = 1'b0;
        tkeep  = '1;
        @(posedge clk);
        #1;
        pkt_addr_valid = 1'b1;
        pkt_addr       = 11'h077;
        @(posedge clk);
        #1;
        pkt_addr_valid = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_output("mid_rst_tready", tready, 1'b0);
        check_output("mid_rst_data_wr_en", data_wr_en, 1'b0);
        check_output("mid_rst_pb_valid", pb_valid, 1'b0);
        check_output("mid_rst_pb_addr", pb_pkt_addr, '0);
        exp_acc = 0; exp_drop = 0; exp_to = 0; exp_skip = 0;
        check_stats("mid_rst");
        tvalid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        apply_stimulus(8'h40, 2, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 11'h2A5, 11'h15A);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
